jedro_1_id_stage: RTL and testbench

//  RV32I decode stage directly downstream of the instruction fetch unit. Accepts instr/addr with valid/ready
//  (drives the fetch unit's ready input), decodes into operand/immediate/ALU controls and registers them in a

---
 rtl/jedro_1_id_stage.sv | 285 ++++++++++++++++++++++++++++
 tb/tb_jedro_1_id_stage.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jedro_1_id_stage.sv
// -----------------------------------------------------------------------------
// jedro_1_id_stage
//   RV32I instruction decode stage sitting between the fetch unit and execute.
//   An instruction offered with valid_i is decoded combinationally and captured
//   into a single output slot on the next clock edge; execute drains the slot
//   with ex_ready_i. Illegal encodings travel as ordinary valid slots tagged
//   with class 7. flush_i empties the slot and drops the incoming instruction.
//
// Ports
//   clk_i, rstn_i           clock, synchronous active-low reset
//   instr_i, addr_i         instruction word and its PC from fetch
//   valid_i / ready_o       fetch-side handshake (ready_o is combinational)
//   flush_i                 kill slot and incoming instruction
//   ex_valid_o / ex_ready_i execute-side handshake for the output slot
//   ex_class_o              0 ALU,1 LOAD,2 STORE,3 BRANCH,4 JAL,5 JALR,6 SYSTEM,7 ILLEGAL
//   ex_alu_op_o             0 ADD,1 SUB,2 SLL,3 SLT,4 SLTU,5 XOR,6 SRL,7 SRA,8 OR,9 AND
//   ex_funct3_o             raw funct3
//   ex_rs1_o/rs2_o/rd_o     register addresses, ex_rd_we_o = write rd
//   ex_imm_o                sign-extended immediate (0 for R-type and illegal)
//   ex_use_imm_o/use_pc_o   operand B = imm / operand A = PC
//   ex_pc_o                 PC of the slot
//   stall_cnt_o             cycles with ex_valid_o=1 and ex_ready_i=0
//
// Configuration
//   JEDRO_1_ID_STALL_CNT_EN  when defined, builds the 32-bit stall counter;
//                            otherwise stall_cnt_o is tied to zero.
// -----------------------------------------------------------------------------
module jedro_1_id_stage #(
    parameter int unsigned               DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0]     NOP_INSTR  = 32'h0000_0013
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    input  logic [DATA_WIDTH-1:0] instr_i,
    input  logic [DATA_WIDTH-1:0] addr_i,
    input  logic                  valid_i,
    output logic                  ready_o,
    input  logic                  flush_i,
    output logic                  ex_valid_o,
    input  logic                  ex_ready_i,
    output logic [2:0]            ex_class_o,
    output logic [3:0]            ex_alu_op_o,
    output logic [2:0]            ex_funct3_o,
    output logic [4:0]            ex_rs1_o,
    output logic [4:0]            ex_rs2_o,
    output logic [4:0]            ex_rd_o,
    output logic                  ex_rd_we_o,
    output logic [DATA_WIDTH-1:0] ex_imm_o,
    output logic                  ex_use_imm_o,
    output logic                  ex_use_pc_o,
    output logic [DATA_WIDTH-1:0] ex_pc_o,
    output logic [31:0]           stall_cnt_o
);

    // Opcodes. Every one ends in 2'b11, so an instruction with ins[1:0]!=2'b11
    // can never match and falls into the illegal default.
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = NOP_INSTR[6:0];  // NOP is ADDI, i.e. OP-IMM
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    localparam logic [2:0] CLS_ALU     = 3'd0;
    localparam logic [2:0] CLS_LOAD    = 3'd1;
    localparam logic [2:0] CLS_STORE   = 3'd2;
    localparam logic [2:0] CLS_BRANCH  = 3'd3;
    localparam logic [2:0] CLS_JAL     = 3'd4;
    localparam logic [2:0] CLS_JALR    = 3'd5;
    localparam logic [2:0] CLS_SYSTEM  = 3'd6;
    localparam logic [2:0] CLS_ILLEGAL = 3'd7;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_SLL  = 4'd2;
    localparam logic [3:0] ALU_SLT  = 4'd3;
    localparam logic [3:0] ALU_SLTU = 4'd4;
    localparam logic [3:0] ALU_XOR  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_OR   = 4'd8;
    localparam logic [3:0] ALU_AND  = 4'd9;

    localparam logic [6:0] F7_ZERO = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    assign opcode = instr_i[6:0];
    assign funct3 = instr_i[14:12];
    assign funct7 = instr_i[31:25];

    logic [DATA_WIDTH-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    assign imm_i = {{(DATA_WIDTH-12){instr_i[31]}}, instr_i[31:20]};
    assign imm_s = {{(DATA_WIDTH-12){instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
    assign imm_b = {{(DATA_WIDTH-13){instr_i[31]}}, instr_i[31], instr_i[7],
                    instr_i[30:25], instr_i[11:8], 1'b0};
    assign imm_u = {instr_i[31:12], 12'b0};
    assign imm_j = {{(DATA_WIDTH-21){instr_i[31]}}, instr_i[31], instr_i[19:12],
                    instr_i[20], instr_i[30:21], 1'b0};

    // ALU op implied by funct3 alone (the non-alternate variant).
    logic [3:0] alu_base;
    always_comb begin
        alu_base = ALU_ADD;
        case (funct3)
            3'd0: alu_base = ALU_ADD;
            3'd1: alu_base = ALU_SLL;
            3'd2: alu_base = ALU_SLT;
            3'd3: alu_base = ALU_SLTU;
            3'd4: alu_base = ALU_XOR;
            3'd5: alu_base = ALU_SRL;
            3'd6: alu_base = ALU_OR;
            3'd7: alu_base = ALU_AND;
            default: alu_base = ALU_ADD;
        endcase
    end

    logic [2:0]            class_d;
    logic [3:0]            alu_op_d;
    logic [DATA_WIDTH-1:0] imm_d;
    logic                  use_imm_d, use_pc_d, rd_we_d;
    logic [4:0]            rs1_d;
    logic                  legal;
    logic                  writes_rd;

    always_comb begin
        class_d   = CLS_ILLEGAL;
        alu_op_d  = ALU_ADD;
        imm_d     = '0;
        use_imm_d = 1'b0;
        use_pc_d  = 1'b0;
        rs1_d     = instr_i[19:15];
        legal     = 1'b0;
        writes_rd = 1'b0;
        case (opcode)
            OPC_LUI: begin
                legal = 1'b1; class_d = CLS_ALU; imm_d = imm_u;
                use_imm_d = 1'b1; rs1_d = 5'd0; writes_rd = 1'b1;
            end
            OPC_AUIPC: begin
                legal = 1'b1; class_d = CLS_ALU; imm_d = imm_u;
                use_imm_d = 1'b1; use_pc_d = 1'b1; writes_rd = 1'b1;
            end
            OPC_JAL: begin
                legal = 1'b1; class_d = CLS_JAL; imm_d = imm_j;
                use_imm_d = 1'b1; use_pc_d = 1'b1; writes_rd = 1'b1;
            end
            OPC_JALR: begin
                legal = (funct3 == 3'd0); class_d = CLS_JALR; imm_d = imm_i;
                use_imm_d = 1'b1; writes_rd = 1'b1;
            end
            OPC_BRANCH: begin
                legal = (funct3 != 3'd2) && (funct3 != 3'd3);
                class_d = CLS_BRANCH; alu_op_d = ALU_SUB; imm_d = imm_b;
            end
            OPC_LOAD: begin
                legal = (funct3 != 3'd3) && (funct3 != 3'd6) && (funct3 != 3'd7);
                class_d = CLS_LOAD; imm_d = imm_i; use_imm_d = 1'b1; writes_rd = 1'b1;
            end
            OPC_STORE: begin
                legal = (funct3 <= 3'd2); class_d = CLS_STORE; imm_d = imm_s; use_imm_d = 1'b1;
            end
            OPC_OP_IMM: begin
                class_d = CLS_ALU; imm_d = imm_i; use_imm_d = 1'b1; writes_rd = 1'b1;
                alu_op_d = alu_base;
                // Only the shifts constrain the upper immediate bits.
                case (funct3)
                    3'd1: legal = (funct7 == F7_ZERO);
                    3'd5: begin
                        legal = (funct7 == F7_ZERO) || (funct7 == F7_ALT);
                        if (funct7 == F7_ALT) alu_op_d = ALU_SRA;
                    end
                    default: legal = 1'b1;
                endcase
            end
            OPC_OP: begin
                class_d = CLS_ALU; writes_rd = 1'b1; alu_op_d = alu_base;
                if (funct7 == F7_ZERO) begin
                    legal = 1'b1;
                end else if (funct7 == F7_ALT && funct3 == 3'd0) begin
                    legal = 1'b1; alu_op_d = ALU_SUB;
                end else if (funct7 == F7_ALT && funct3 == 3'd5) begin
                    legal = 1'b1; alu_op_d = ALU_SRA;
                end
            end
            OPC_FENCE: begin
                legal = (funct3 <= 3'd1); class_d = CLS_SYSTEM; imm_d = imm_i;
            end
            OPC_SYSTEM: begin
                legal = (funct3 != 3'd4); class_d = CLS_SYSTEM; imm_d = imm_i;
            end
            default: legal = 1'b0;
        endcase
        if (!legal) begin
            class_d   = CLS_ILLEGAL;
            alu_op_d  = ALU_ADD;
            imm_d     = '0;
            use_imm_d = 1'b0;
            use_pc_d  = 1'b0;
            writes_rd = 1'b0;
        end
    end
    assign rd_we_d = writes_rd & (instr_i[11:7] != 5'd0);

    logic                  ex_valid_q;
    logic [2:0]            ex_class_q;
    logic [3:0]            ex_alu_op_q;
    logic [2:0]            ex_funct3_q;
    logic [4:0]            ex_rs1_q, ex_rs2_q, ex_rd_q;
    logic                  ex_rd_we_q, ex_use_imm_q, ex_use_pc_q;
    logic [DATA_WIDTH-1:0] ex_imm_q, ex_pc_q;
    logic                  accept;

    // Ready depends only on slot state and ex_ready_i, never on valid_i.
    assign ready_o = ~rstn_i | ~ex_valid_q | ex_ready_i;
    assign accept  = valid_i & ready_o & ~flush_i;

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            ex_valid_q   <= 1'b0;
            ex_class_q   <= '0;
            ex_alu_op_q  <= '0;
            ex_funct3_q  <= '0;
            ex_rs1_q     <= '0;
            ex_rs2_q     <= '0;
            ex_rd_q      <= '0;
            ex_rd_we_q   <= 1'b0;
            ex_imm_q     <= '0;
            ex_use_imm_q <= 1'b0;
            ex_use_pc_q  <= 1'b0;
            ex_pc_q      <= '0;
        end else begin
            if (flush_i)         ex_valid_q <= 1'b0;
            else if (accept)     ex_valid_q <= 1'b1;
            else if (ex_ready_i) ex_valid_q <= 1'b0;
            if (accept) begin
                ex_class_q   <= class_d;
                ex_alu_op_q  <= alu_op_d;
                ex_funct3_q  <= funct3;
                ex_rs1_q     <= rs1_d;
                ex_rs2_q     <= instr_i[24:20];
                ex_rd_q      <= instr_i[11:7];
                ex_rd_we_q   <= rd_we_d;
                ex_imm_q     <= imm_d;
                ex_use_imm_q <= use_imm_d;
                ex_use_pc_q  <= use_pc_d;
                ex_pc_q      <= addr_i;
            end
        end
    end

    assign ex_valid_o   = ex_valid_q;
    assign ex_class_o   = ex_class_q;
    assign ex_alu_op_o  = ex_alu_op_q;
    assign ex_funct3_o  = ex_funct3_q;
    assign ex_rs1_o     = ex_rs1_q;
    assign ex_rs2_o     = ex_rs2_q;
    assign ex_rd_o      = ex_rd_q;
    assign ex_rd_we_o   = ex_rd_we_q;
    assign ex_imm_o     = ex_imm_q;
    assign ex_use_imm_o = ex_use_imm_q;
    assign ex_use_pc_o  = ex_use_pc_q;
    assign ex_pc_o      = ex_pc_q;

`ifdef JEDRO_1_ID_STALL_CNT_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] stall_cnt_d;
    assign stall_cnt_d = (ex_valid_q && !ex_ready_i) ? stall_cnt_q + 32'd1 : stall_cnt_q;
    always_ff @(posedge clk_i) begin
        if (!rstn_i) stall_cnt_q <= '0;
        else         stall_cnt_q <= stall_cnt_d;
    end
    assign stall_cnt_o = stall_cnt_q;
`else
    assign stall_cnt_o = 32'd0;
`endif

endmodule

// File: tb/tb_jedro_1_id_stage.sv
// -----------------------------------------------------------------------------
// tb_jedro_1_id_stage
//   Scoreboard bench for jedro_1_id_stage. The driver issues one cycle of
//   stimulus at a time and, at the clock edge, pushes the expected decode of
//   every accepted instruction; the monitor checks the DUT on the falling edge
//   and pops an entry whenever execute takes the slot.
// -----------------------------------------------------------------------------
module tb_jedro_1_id_stage;

    logic        clk;
    logic        rstn;
    logic [31:0] instr;
    logic [31:0] addr;
    logic        valid;
    logic        ready_o;
    logic        flush;
    logic        ex_valid_o;
    logic        ex_ready;
    logic [2:0]  ex_class_o;
    logic [3:0]  ex_alu_op_o;
    logic [2:0]  ex_funct3_o;
    logic [4:0]  ex_rs1_o, ex_rs2_o, ex_rd_o;
    logic        ex_rd_we_o;
    logic [31:0] ex_imm_o;
    logic        ex_use_imm_o, ex_use_pc_o;
    logic [31:0] ex_pc_o;
    logic [31:0] stall_cnt_o;

    jedro_1_id_stage dut (
        .clk_i        (clk),
        .rstn_i       (rstn),
        .instr_i      (instr),
        .addr_i       (addr),
        .valid_i      (valid),
        .ready_o      (ready_o),
        .flush_i      (flush),
        .ex_valid_o   (ex_valid_o),
        .ex_ready_i   (ex_ready),
        .ex_class_o   (ex_class_o),
        .ex_alu_op_o  (ex_alu_op_o),
        .ex_funct3_o  (ex_funct3_o),
        .ex_rs1_o     (ex_rs1_o),
        .ex_rs2_o     (ex_rs2_o),
        .ex_rd_o      (ex_rd_o),
        .ex_rd_we_o   (ex_rd_we_o),
        .ex_imm_o     (ex_imm_o),
        .ex_use_imm_o (ex_use_imm_o),
        .ex_use_pc_o  (ex_use_pc_o),
        .ex_pc_o      (ex_pc_o),
        .stall_cnt_o  (stall_cnt_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct packed {
        logic [31:0] instr;
        logic [2:0]  cls;
        logic [3:0]  alu;
        logic [2:0]  f3;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        rd_we;
        logic [31:0] imm;
        logic        use_imm;
        logic        use_pc;
        logic [31:0] pc;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    int unsigned exp_cnt = 0;
    bit          started = 0;
    bit          fields_zero = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h", name, act, exp);
        end
    endtask

    // ALU code of the plain (non-alternate) operation for a given funct3.
    function automatic logic [3:0] alu_of(input logic [2:0] f3);
        case (f3)
            3'd0: return 4'd0;   // ADD
            3'd1: return 4'd2;   // SLL
            3'd2: return 4'd3;   // SLT
            3'd3: return 4'd4;   // SLTU
            3'd4: return 4'd5;   // XOR
            3'd5: return 4'd6;   // SRL
            3'd6: return 4'd8;   // OR
            default: return 4'd9; // AND
        endcase
    endfunction

    // Reference decode written straight from the RV32I encoding rules.
    function automatic exp_t ref_decode(input logic [31:0] ins, input logic [31:0] pc);
        exp_t e;
        logic ok, wr;
        logic [2:0] f3;
        logic [6:0] f7;
        logic [31:0] i_imm, s_imm, b_imm, u_imm, j_imm;
        f3 = ins[14:12];
        f7 = ins[31:25];
        i_imm = 32'($signed(ins[31:20]));
        s_imm = 32'($signed({ins[31:25], ins[11:7]}));
        b_imm = 32'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
        u_imm = ins & 32'hFFFF_F000;
        j_imm = 32'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}));
        e = '0;
        e.instr = ins; e.pc = pc; e.f3 = f3;
        e.rs1 = ins[19:15]; e.rs2 = ins[24:20]; e.rd = ins[11:7];
        e.cls = 3'd7; ok = 1'b0; wr = 1'b0;
        case (ins[6:0])
            7'h37: begin ok = 1; e.cls = 0; e.imm = u_imm; e.use_imm = 1; e.rs1 = 0; wr = 1; end
            7'h17: begin ok = 1; e.cls = 0; e.imm = u_imm; e.use_imm = 1; e.use_pc = 1; wr = 1; end
            7'h6F: begin ok = 1; e.cls = 4; e.imm = j_imm; e.use_imm = 1; e.use_pc = 1; wr = 1; end
            7'h67: begin ok = (f3 == 0); e.cls = 5; e.imm = i_imm; e.use_imm = 1; wr = 1; end
            7'h63: begin ok = !(f3 inside {3'd2, 3'd3}); e.cls = 3; e.alu = 1; e.imm = b_imm; end
            7'h03: begin ok = !(f3 inside {3'd3, 3'd6, 3'd7}); e.cls = 1; e.imm = i_imm; e.use_imm = 1; wr = 1; end
            7'h23: begin ok = (f3 <= 2); e.cls = 2; e.imm = s_imm; e.use_imm = 1; end
            7'h13: begin
                e.cls = 0; e.imm = i_imm; e.use_imm = 1; wr = 1; e.alu = alu_of(f3);
                if (f3 == 1)      ok = (f7 == 0);
                else if (f3 == 5) ok = (f7 == 0) || (f7 == 7'h20);
                else              ok = 1;
                if (f3 == 5 && f7 == 7'h20) e.alu = e.alu + 4'd1;
            end
            7'h33: begin
                e.cls = 0; wr = 1; e.alu = alu_of(f3);
                ok = (f7 == 0) || (f7 == 7'h20 && (f3 == 0 || f3 == 5));
                if (ok && f7 == 7'h20) e.alu = e.alu + 4'd1;
            end
            7'h0F: begin ok = (f3 <= 1); e.cls = 6; e.imm = i_imm; end
            7'h73: begin ok = (f3 != 4); e.cls = 6; e.imm = i_imm; end
            default: ok = 0;
        endcase
        if (!ok) begin
            e.cls = 7; e.alu = 0; e.imm = 0; e.use_imm = 0; e.use_pc = 0; wr = 0;
        end
        e.rd_we = wr && (e.rd != 0);
        return e;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 11))
            0:  r[6:0] = 7'h37;
            1:  r[6:0] = 7'h17;
            2:  r[6:0] = 7'h6F;
            3:  r[6:0] = 7'h67;
            4:  r[6:0] = 7'h63;
            5:  r[6:0] = 7'h03;
            6:  r[6:0] = 7'h23;
            7:  r[6:0] = 7'h13;
            8:  r[6:0] = 7'h33;
            9:  r[6:0] = 7'h0F;
            10: r[6:0] = 7'h73;
            default: ;
        endcase
        case ($urandom_range(0, 3))
            0: r[31:25] = 7'h00;
            1: r[31:25] = 7'h20;
            default: ;
        endcase
        return r;
    endfunction

    // One cycle of stimulus, then the reference model's view of the clock edge.
    task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                         input logic fl, input logic rdy, input logic rn);
        bit model_ready;
        valid = v; instr = ins; addr = pc; flush = fl; ex_ready = rdy; rstn = rn;
        @(posedge clk);
        if (!rn) begin
            sb.delete();
            exp_cnt = 0;
            fields_zero = 1;
        end else begin
`ifdef JEDRO_1_ID_STALL_CNT_EN
            if (sb.size() != 0 && !rdy) exp_cnt++;
`endif
            model_ready = (sb.size() == 0) || rdy;
            if (fl) begin
                if (sb.size() != 0) void'(sb.pop_front());
            end else if (v && model_ready) begin
                sb.push_back(ref_decode(ins, pc));
                fields_zero = 0;
            end
        end
        started = 1;
        #1;
    endtask

    // Monitor: samples on the falling edge, compares against the queue head.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (started) begin
                check("ready_o", {31'd0, ready_o}, {31'd0, (!rstn) || (sb.size() == 0) || ex_ready});
                check("ex_valid_o", {31'd0, ex_valid_o}, {31'd0, sb.size() != 0});
                check("stall_cnt_o", stall_cnt_o, exp_cnt);
                if (sb.size() != 0) begin
                    e = sb[0];
                    check("class", {29'd0, ex_class_o}, {29'd0, e.cls});
                    check("alu_op", {28'd0, ex_alu_op_o}, {28'd0, e.alu});
                    check("funct3", {29'd0, ex_funct3_o}, {29'd0, e.f3});
                    check("rs1", {27'd0, ex_rs1_o}, {27'd0, e.rs1});
                    check("rs2", {27'd0, ex_rs2_o}, {27'd0, e.rs2});
                    check("rd", {27'd0, ex_rd_o}, {27'd0, e.rd});
                    check("rd_we", {31'd0, ex_rd_we_o}, {31'd0, e.rd_we});
                    check("imm", ex_imm_o, e.imm);
                    check("use_imm", {31'd0, ex_use_imm_o}, {31'd0, e.use_imm});
                    check("use_pc", {31'd0, ex_use_pc_o}, {31'd0, e.use_pc});
                    check("pc", ex_pc_o, e.pc);
                    if (ex_ready) begin
                        $display("txn pc=%h instr=%h class=%0d alu=%0d rd=%0d we=%0d imm=%h",
                                 e.pc, e.instr, e.cls, e.alu, e.rd, e.rd_we, e.imm);
                        void'(sb.pop_front());
                    end
                end else if (fields_zero) begin
                    check("reset_fields_a", {ex_class_o, ex_alu_op_o, ex_funct3_o, ex_rs1_o,
                                             ex_rs2_o, ex_rd_o, ex_rd_we_o, ex_use_imm_o,
                                             ex_use_pc_o, 4'd0}, 32'd0);
                    check("reset_imm", ex_imm_o, 32'd0);
                    check("reset_pc", ex_pc_o, 32'd0);
                end
            end
        end
    end

    initial begin
        // Reset with idle inputs.
        drive(0, 32'h0, 32'h0, 0, 1, 0);
        drive(0, 32'h0, 32'h0, 0, 1, 0);
        drive(0, 32'h0, 32'h0, 0, 1, 1);

        // Directed decodes from the bring-up list, streamed back to back.
        drive(1, 32'hFFF10093, 32'h0000_0000, 0, 1, 1);  // addi x1,x2,-1
        drive(1, 32'hFE000EE3, 32'h0000_0100, 0, 1, 1);  // beq x0,x0,-4
        drive(1, 32'h4041D193, 32'h0000_0104, 0, 1, 1);  // srai x3,x3,4
        drive(1, 32'hC041D193, 32'h0000_0108, 0, 1, 1);  // bad funct7
        drive(1, 32'h0000_0000, 32'h0000_010C, 0, 1, 1);  // all-zero word
        drive(1, 32'h0000_0013, 32'h0000_0110, 0, 1, 1);  // nop
        drive(0, 32'h0, 32'h0, 0, 1, 1);

        // Backpressure: hold the slot for 5 cycles with the next instr waiting.
        drive(1, 32'h00500293, 32'h0000_0200, 0, 0, 1);  // addi x5,x0,5
        for (int i = 0; i < 5; i++) drive(1, 32'h00A28313, 32'h0000_0204, 0, 0, 1);
        drive(1, 32'h00A28313, 32'h0000_0204, 0, 1, 1);
        drive(0, 32'h0, 32'h0, 0, 1, 1);

        // Flush on the accepting cycle drops the incoming instruction.
        drive(1, 32'h00100393, 32'h0000_0300, 1, 1, 1);
        drive(0, 32'h0, 32'h0, 0, 1, 1);
        // Flush of a stalled slot.
        drive(1, 32'h00200413, 32'h0000_0304, 0, 0, 1);
        drive(0, 32'h0, 32'h0, 1, 0, 1);
        drive(0, 32'h0, 32'h0, 0, 1, 1);

        // Reset while the slot is valid and stalled.
        drive(1, 32'h00300493, 32'h0000_0400, 0, 0, 1);
        drive(1, 32'h00400513, 32'h0000_0404, 0, 0, 1);
        drive(1, 32'h00400513, 32'h0000_0404, 0, 0, 0);
        drive(0, 32'h0, 32'h0, 0, 0, 1);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            drive(($urandom % 4) != 0, rand_instr(), $urandom & 32'hFFFF_FFFC,
                  ($urandom % 16) == 0, ($urandom % 3) != 0, ($urandom % 200) != 0);
        end

        // Drain.
        for (int i = 0; i < 3; i++) drive(0, 32'h0, 32'h0, 0, 1, 1);
        check("scoreboard_empty", sb.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
